// File: rtl/i2c_write_master.sv
// i2c_write_master: bit-level I2C master for a single NBYTES-byte write.
// Sequence: START, NBYTES bytes MSB first with an ACK slot after each, STOP.
// Every I2C bit spans four clk_i2c cycles (phases 0..3); SCL is low in
// phases 0-1 and high in phases 2-3 while bits are shifted out.
//
// Ports:
//   clk_i2c   controller clock (10 kHz)
//   reset_n   asynchronous active-low reset; aborts any transfer, no STOP
//   i2c_data  {byte0, byte1, byte2}, latched when go is accepted in IDLE
//   go        level request, accepted only in IDLE
//   done      high in DONE, held until go is low
//   busy      high from acceptance until the transfer reaches DONE
//   ack_err   NACK flags, [NBYTES-1] = byte0 ... [0] = last byte
//   i2c_sclk  SCL, push-pull, registered
//   i2c_sdat  SDA, open-drain (drives 0 or Z only), registered enable
module i2c_write_master #(
  parameter int unsigned NBYTES = 3
) (
  input  logic                  clk_i2c,
  input  logic                  reset_n,
  input  logic [8*NBYTES-1:0]   i2c_data,
  input  logic                  go,
  output logic                  done,
  output logic                  busy,
  output logic [NBYTES-1:0]     ack_err,
  output logic                  i2c_sclk,
  inout  wire                   i2c_sdat
);

  localparam int unsigned DataW = 8 * NBYTES;
  localparam int unsigned ByteW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StBits,
    StStop,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  // bit_q counts 0..8 within a byte; 8 is the ACK slot.
  logic [3:0]         bit_q, bit_d;
  logic [ByteW-1:0]   byte_q, byte_d;
  logic [DataW-1:0]   shift_q, shift_d;
  logic [NBYTES-1:0]  ack_err_q, ack_err_d;
  logic               scl_q, scl_d;
  logic               sda_oe_q, sda_oe_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               sda_in;

  assign sda_in   = i2c_sdat;
  assign i2c_sdat = sda_oe_q ? 1'b0 : 1'bz;
  assign i2c_sclk = scl_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign ack_err  = ack_err_q;

  // Next-state logic for the sequencer.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    ack_err_d = ack_err_q;

    unique case (state_q)
      StIdle: begin
        if (go) begin
          state_d   = StStart;
          phase_d   = 2'd0;
          bit_d     = 4'd0;
          byte_d    = '0;
          shift_d   = i2c_data;
          ack_err_d = '0;
        end
      end

      StStart: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          state_d = StBits;
        end
      end

      StBits: begin
        phase_d = phase_q + 2'd1;
        // ACK sampled on the edge that ends phase 2 (SCL high, settled).
        if (phase_q == 2'd2 && bit_q == 4'd8) begin
          for (int i = 0; i < NBYTES; i++) begin
            if (byte_q == ByteW'(NBYTES - 1 - i)) begin
              ack_err_d[i] = sda_in;
            end
          end
        end
        if (phase_q == 2'd3) begin
          if (bit_q == 4'd8) begin
            bit_d = 4'd0;
            if (byte_q == ByteW'(NBYTES - 1)) begin
              state_d = StStop;
            end else begin
              byte_d = byte_q + ByteW'(1);
            end
          end else begin
            // Only data slots consume a bit from the shift register.
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q << 1;
          end
        end
      end

      StStop: begin
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          state_d = StDone;
        end
      end

      StDone: begin
        if (!go) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output values for the cycle that follows the edge: decoding the next
  // state keeps SCL/SDA registered and aligned with the current state.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    unique case (state_d)
      StStart: begin
        sda_oe_d = phase_d[1];
      end
      StBits: begin
        scl_d    = phase_d[1];
        // bit_d/shift_d only move at the phase 3 -> 0 step, so SDA is
        // stable across the whole slot.
        sda_oe_d = (bit_d != 4'd8) && !shift_d[DataW-1];
      end
      StStop: begin
        scl_d    = (phase_d != 2'd0);
        sda_oe_d = !phase_d[1];
      end
      default: begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  assign done_d = (state_d == StDone);
  assign busy_d = (state_d == StStart) || (state_d == StBits) || (state_d == StStop);

  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      phase_q   <= 2'd0;
      bit_q     <= 4'd0;
      byte_q    <= '0;
      shift_q   <= '0;
      ack_err_q <= '0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      shift_q   <= shift_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: a bus monitor decodes START/STOP and the bits
// clocked on SCL rising edges, a slave model ACKs or NACKs per byte, and a
// scoreboard queue holds the expected bytes and ack_err for each transfer.
module tb_i2c_write_master;

  logic        clk;
  logic        reset_n;
  logic [23:0] i2c_data;
  logic        go;
  logic        done;
  logic        busy;
  logic [2:0]  ack_err;
  logic        scl;
  wire         sda_line;

  logic        slave_low;
  logic [2:0]  nack_mask;

  pullup (sda_line);
  assign sda_line = slave_low ? 1'b0 : 1'bz;

  i2c_write_master #(
    .NBYTES(3)
  ) dut (
    .clk_i2c  (clk),
    .reset_n  (reset_n),
    .i2c_data (i2c_data),
    .go       (go),
    .done     (done),
    .busy     (busy),
    .ack_err  (ack_err),
    .i2c_sclk (scl),
    .i2c_sdat (sda_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus monitor and slave model.
  int          start_cnt = 0;
  int          stop_cnt  = 0;
  int          nbits     = 0;
  int          cap_bits  = 0;
  logic [31:0] rx        = '0;
  logic [31:0] cap_rx    = '0;
  logic        prev_scl  = 1'b1;
  logic        prev_sda  = 1'b1;

  initial slave_low = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      slave_low = 1'b0;
    end else begin
      if (prev_scl && scl && prev_sda && !sda_line) begin
        start_cnt++;
        nbits = 0;
        rx    = '0;
      end else if (prev_scl && scl && !prev_sda && sda_line) begin
        stop_cnt++;
        cap_rx   = rx;
        cap_bits = nbits;
      end else if (!prev_scl && scl) begin
        rx = {rx[30:0], sda_line};
        nbits++;
      end else if (prev_scl && !scl) begin
        if (nbits == 8 || nbits == 17 || nbits == 26) begin
          slave_low = !nack_mask[2 - nbits / 9];
        end else begin
          slave_low = 1'b0;
        end
      end
    end
    prev_scl = scl;
    prev_sda = sda_line;
  end

  // Scoreboard and checking.
  typedef struct {
    logic [23:0] data;
    logic [2:0]  err;
  } exp_t;

  typedef struct {
    logic [23:0] data;
    logic [2:0]  nack;
    logic [2:0]  err;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[4];
  int   checks;
  int   errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input logic [23:0] data, input logic [2:0] nack,
                         input logic [2:0] err, input bit drop_go, input string tag);
    int   cyc;
    int   guard;
    int   busy_gap;
    int   s0;
    int   p0;
    exp_t e;
    guard    = 0;
    busy_gap = 0;
    while ((busy || done) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    s0        = start_cnt;
    p0        = stop_cnt;
    nack_mask = nack;
    i2c_data  = data;
    go        = 1'b1;
    sb_q.push_back('{data, err});
    @(posedge clk); #1;
    check($sformatf("%s busy_at_accept", tag), 32'(busy), 32'd1);
    check($sformatf("%s ack_err_cleared", tag), 32'(ack_err), 32'd0);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (drop_go && cyc == 40) begin
        go       = 1'b0;
        i2c_data = 24'hFFFFFF;
      end
      if (!done && !busy) busy_gap++;
    end
    check($sformatf("%s done_latency", tag), 32'(cyc), 32'd116);
    check($sformatf("%s busy_gap", tag), 32'(busy_gap), 32'd0);
    check($sformatf("%s busy_in_done", tag), 32'(busy), 32'd0);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
    end else begin
      e = '{24'h0, 3'h0};
      check($sformatf("%s scoreboard_empty", tag), 32'd1, 32'd0);
    end
    check($sformatf("%s bytes", tag),
          32'({cap_rx[27:20], cap_rx[18:11], cap_rx[9:2]}), 32'(e.data));
    check($sformatf("%s ack_bits_on_bus", tag),
          32'({cap_rx[19], cap_rx[10], cap_rx[1]}), 32'(e.err));
    check($sformatf("%s ack_err", tag), 32'(ack_err), 32'(e.err));
    check($sformatf("%s start_count", tag), 32'(start_cnt - s0), 32'd1);
    check($sformatf("%s stop_count", tag), 32'(stop_cnt - p0), 32'd1);
    check($sformatf("%s scl_edges", tag), 32'(cap_bits), 32'd28);
    check($sformatf("%s bus_idle", tag), 32'({scl, sda_line}), 32'b11);
    if (!drop_go) begin
      repeat (2) begin
        @(posedge clk); #1;
        check($sformatf("%s done_held", tag), 32'({done, busy}), 32'b10);
      end
      go = 1'b0;
    end
    @(posedge clk); #1;
    check($sformatf("%s done_falls", tag), 32'(done), 32'd0);
    check($sformatf("%s ack_err_holds", tag), 32'(ack_err), 32'(e.err));
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    go        = 1'b0;
    i2c_data  = '0;
    nack_mask = '0;
    reset_n   = 1'b0;

    vecs[0] = '{24'h341E00, 3'b000, 3'b000};
    vecs[1] = '{24'h340474, 3'b010, 3'b010};
    vecs[2] = '{24'h340474, 3'b000, 3'b000};
    vecs[3] = '{24'h34FF55, 3'b101, 3'b101};

    repeat (3) @(posedge clk);
    #1;
    check("reset scl", 32'(scl), 32'd1);
    check("reset sda", 32'(sda_line), 32'd1);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset ack_err", 32'(ack_err), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table vectors run back to back: go drops for exactly one edge between.
    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i].data, vecs[i].nack, vecs[i].err, 1'b0, $sformatf("vec%0d", i));
    end

    // go dropped and data scrambled mid-transfer.
    run_txn(24'h341E00, 3'b000, 3'b000, 1'b1, "go_drop");

    // Reset at slot 12, phase 2 (byte1 bit 4 of 0x04 is 0, so SDA is low).
    nack_mask = 3'b000;
    i2c_data  = 24'h340474;
    go        = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (54) @(posedge clk);
    #1;
    check("abort pre scl/sda", 32'({scl, sda_line}), 32'b10);
    reset_n = 1'b0;
    #1;
    check("abort scl", 32'(scl), 32'd1);
    check("abort sda", 32'(sda_line), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_abort idle", 32'({scl, sda_line, busy, done}), 32'b1100);
    run_txn(24'h340C00, 3'b000, 3'b000, 1'b0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
